// File: rtl/lift_ctrl.sv
// -----------------------------------------------------------------------------
// lift_ctrl : lift motion controller and direction source for the UP/dn
// seven-segment display logic.
//
// Latches floor calls, moves the car one floor per FLOOR_TICKS slowref ticks,
// stops at called floors for DOOR_TICKS slowref ticks, and keeps travelling
// in the same direction while calls remain ahead before reversing.
//
// Ports:
//   clk        in   system clock
//   resetb     in   asynchronous active-low reset
//   slowref    in   one-clk-wide timebase tick, synchronous to clk
//   req        in   floor call buttons, bit i = floor i (any pulse width)
//   upsig      out  direction is up (sticky, registered)
//   dnsig      out  direction is down (sticky, registered)
//   moving     out  car travelling between floors
//   floor      out  current floor index (0 = bottom)
//   door_open  out  door open at current floor
//   pending    out  latched, unserved calls
// -----------------------------------------------------------------------------
module lift_ctrl #(
  parameter int NFLOORS     = 4,
  parameter int FW          = 2,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 6
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               slowref,
  input  logic [NFLOORS-1:0] req,
  output logic               upsig,
  output logic               dnsig,
  output logic               moving,
  output logic [FW-1:0]      floor,
  output logic               door_open,
  output logic [NFLOORS-1:0] pending
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(NFLOORS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [FW-1:0]      floor_nx;
  logic [NFLOORS-1:0] pending_nx;
  logic               upsig_nx, dnsig_nx;

  logic [NFLOORS-1:0] cur_mask;     // one-hot of the current floor
  logic [NFLOORS-1:0] step_mask;    // one-hot of the floor being approached
  logic [FW-1:0]      step_floor;   // next floor in the current direction
  logic [NFLOORS-1:0] pend_all;     // registered calls plus calls latched now
  logic               cur_hit;      // call button pressed at the current floor
  logic               at_end;       // car already at the end stop it heads for
  logic               ahead_after;  // calls remain beyond step_floor
  logic               above, below; // registered calls relative to floor

  function automatic logic [NFLOORS-1:0] floor_mask(input logic [FW-1:0] f);
    logic [NFLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NFLOORS; i++) m[i] = (int'(f) == i);
    return m;
  endfunction

  function automatic logic calls_above(input logic [NFLOORS-1:0] v,
                                       input logic [FW-1:0]      f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NFLOORS; i++) r = r | (v[i] & (i > int'(f)));
    return r;
  endfunction

  function automatic logic calls_below(input logic [NFLOORS-1:0] v,
                                       input logic [FW-1:0]      f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NFLOORS; i++) r = r | (v[i] & (i < int'(f)));
    return r;
  endfunction

  // Direction of travel in MOVE is carried by upsig; dnsig is its complement
  // whenever the car is moving.
  always_comb begin
    cur_mask    = floor_mask(floor);
    step_floor  = upsig ? (floor + FW'(1)) : (floor - FW'(1));
    step_mask   = floor_mask(step_floor);
    at_end      = upsig ? (floor == TOP_FLOOR) : (floor == '0);
    cur_hit     = |(req & cur_mask);
    // A press at the current floor is served on the spot unless the car is
    // already leaving it, so it is only latched while moving.
    pend_all    = pending | ((state == MOVE) ? req : (req & ~cur_mask));
    ahead_after = upsig ? calls_above(pend_all, step_floor)
                        : calls_below(pend_all, step_floor);
    above       = calls_above(pending, floor);
    below       = calls_below(pending, floor);
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    floor_nx   = floor;
    pending_nx = pend_all;
    upsig_nx   = upsig;
    dnsig_nx   = dnsig;

    unique case (state)
      IDLE: begin
        // Decision uses registered pending: a new call moves the car one
        // clk after it has been latched.
        if (cur_hit) begin
          state_nx = DOOR;
          timer_nx = '0;
        end else if ((upsig && above) || (!dnsig && above) || (dnsig && above && !below)) begin
          state_nx = MOVE;
          timer_nx = '0;
          upsig_nx = 1'b1;
          dnsig_nx = 1'b0;
        end else if (below) begin
          state_nx = MOVE;
          timer_nx = '0;
          upsig_nx = 1'b0;
          dnsig_nx = 1'b1;
        end
      end

      MOVE: begin
        if (slowref) begin
          if (timer == FLOOR_LAST) begin
            timer_nx = '0;
            if (at_end) begin
              // Never drive past an end stop; park and re-decide.
              state_nx = IDLE;
            end else begin
              floor_nx = step_floor;
              if (|(pend_all & step_mask)) begin
                pending_nx = pend_all & ~step_mask;
                state_nx   = DOOR;
              end else if (!ahead_after) begin
                state_nx = IDLE;
              end
            end
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
      end

      DOOR: begin
        // A press at this floor restarts the dwell, overriding any tick.
        if (cur_hit) begin
          timer_nx = '0;
        end else if (slowref) begin
          if (timer == DOOR_LAST) begin
            state_nx = IDLE;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
      end

      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      timer     <= '0;
      floor     <= '0;
      pending   <= '0;
      upsig     <= 1'b0;
      dnsig     <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      floor     <= floor_nx;
      pending   <= pending_nx;
      upsig     <= upsig_nx;
      dnsig     <= dnsig_nx;
      moving    <= (state_nx == MOVE);
      door_open <= (state_nx == DOOR);
    end
  end

endmodule

// File: tb/tb_lift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lift_ctrl : self-checking bench for lift_ctrl.
// Stimulus drives inputs on the falling edge, advances a behavioural model of
// the lift (call set, travel/dwell countdowns) and queues the expected outputs
// for the following rising edge; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_lift_ctrl;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int FT = 4;
  localparam int DT = 6;

  localparam int M_IDLE   = 0;
  localparam int M_TRAVEL = 1;
  localparam int M_DOOR   = 2;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic [NF-1:0] pending;
    logic          up;
    logic          dn;
    logic          mv;
    logic          door;
  } view_t;

  logic          clk = 1'b0;
  logic          resetb;
  logic          slowref;
  logic [NF-1:0] req;
  logic          upsig, dnsig, moving, door_open;
  logic [FW-1:0] floor;
  logic [NF-1:0] pending;

  lift_ctrl #(.NFLOORS(NF), .FW(FW), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .slowref   (slowref),
    .req       (req),
    .upsig     (upsig),
    .dnsig     (dnsig),
    .moving    (moving),
    .floor     (floor),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  view_t sb_q[$];

  // Stimulus control
  logic rst_val   = 1'b0;
  bit   rand_sref = 1'b1;
  int   phase     = 0;

  // Reference model: explicit call list, signed direction, countdown timer.
  int m_floor, m_dir, m_mode, m_left;
  bit m_calls[NF];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_floor = 0;
    m_dir   = 0;
    m_mode  = M_IDLE;
    m_left  = 0;
    for (int i = 0; i < NF; i++) m_calls[i] = 1'b0;
  endtask

  function automatic bit any_call(input bit c[NF], input int from, input int dir);
    bit r = 1'b0;
    for (int i = 0; i < NF; i++)
      if (c[i] && ((dir > 0) ? (i > from) : (i < from))) r = 1'b1;
    return r;
  endfunction

  task automatic model_step(input logic [NF-1:0] r, input logic s, input logic rb);
    bit old_calls[NF];
    bit hit;
    bit up_calls, dn_calls;
    if (!rb) begin
      model_reset();
      return;
    end
    old_calls = m_calls;
    hit = r[m_floor];
    for (int i = 0; i < NF; i++)
      if (r[i] && (m_mode == M_TRAVEL || i != m_floor)) m_calls[i] = 1'b1;
    case (m_mode)
      M_IDLE: begin
        up_calls = any_call(old_calls, m_floor, 1);
        dn_calls = any_call(old_calls, m_floor, -1);
        if (hit) begin
          m_mode = M_DOOR;
          m_left = DT;
        end else if (up_calls || dn_calls) begin
          if (m_dir == 1 && up_calls)       m_dir = 1;
          else if (m_dir == -1 && dn_calls) m_dir = -1;
          else if (up_calls)                m_dir = 1;
          else                              m_dir = -1;
          m_mode = M_TRAVEL;
          m_left = FT;
        end
      end
      M_TRAVEL: begin
        if (s) begin
          m_left--;
          if (m_left == 0) begin
            m_floor += m_dir;
            if (m_calls[m_floor]) begin
              m_calls[m_floor] = 1'b0;
              m_mode = M_DOOR;
              m_left = DT;
            end else if (!any_call(m_calls, m_floor, m_dir)) begin
              m_mode = M_IDLE;
            end else begin
              m_left = FT;
            end
          end
        end
      end
      default: begin
        if (hit) m_left = DT;
        else if (s) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  function automatic view_t model_view();
    view_t v;
    v.floor = FW'(m_floor);
    for (int i = 0; i < NF; i++) v.pending[i] = m_calls[i];
    v.up   = (m_dir == 1);
    v.dn   = (m_dir == -1);
    v.mv   = (m_mode == M_TRAVEL);
    v.door = (m_mode == M_DOOR);
    return v;
  endfunction

  // One clock of stimulus: drive on the falling edge, queue the expectation.
  task automatic step(input logic [NF-1:0] r);
    @(negedge clk);
    req    = r;
    resetb = rst_val;
    if (rand_sref) slowref = ($urandom_range(0, 2) == 0);
    else begin
      slowref = (phase == 4);
      phase   = (phase + 1) % 5;
    end
    model_step(r, slowref, rst_val);
    sb_q.push_back(model_view());
  endtask

  // Idle cycles until a DUT condition holds; counts slowref ticks issued.
  // what: 0 door open, 1 idle (door shut, not moving), 2 moving at floor arg,
  //       3 moving.
  task automatic run_until(input string name, input int what, input int arg,
                           input int budget, output int ticks, output int cycles);
    bit ok = 1'b0;
    ticks  = 0;
    cycles = 0;
    for (int k = 0; k < budget; k++) begin
      step('0);
      cycles++;
      if (slowref) ticks++;
      #7;
      case (what)
        0:       ok = (door_open == 1'b1);
        1:       ok = (!door_open && !moving);
        2:       ok = (moving && int'(floor) == arg);
        default: ok = (moving == 1'b1);
      endcase
      if (ok) break;
    end
    check({"reach_", name}, int'(ok), 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_floor"},   int'(floor),     0);
    check({name, "_pending"}, int'(pending),   0);
    check({name, "_up"},      int'(upsig),     0);
    check({name, "_dn"},      int'(dnsig),     0);
    check({name, "_moving"},  int'(moving),    0);
    check({name, "_door"},    int'(door_open), 0);
  endtask

  // Monitor: compares the DUT against the queued expectation after each edge.
  initial begin
    view_t e, got;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = '{floor, pending, upsig, dnsig, moving, door_open};
        check("cycle", int'(got), int'(e));
      end
    end
  end

  initial begin
    int ticks, cycles, cnt, hold;
    logic [NF-1:0] r;
    resetb  = 1'b0;
    slowref = 1'b0;
    req     = '0;
    model_reset();

    // 1: reset with random activity, then quiet after release.
    rst_val   = 1'b0;
    rand_sref = 1'b1;
    for (int k = 0; k < 20; k++) step(NF'($urandom_range(0, 15)));
    #7;
    check_all_zero("in_reset");
    rst_val   = 1'b1;
    rand_sref = 1'b0;
    for (int k = 0; k < 100; k++) step('0);
    #7;
    check_all_zero("after_release");

    // 2: single up call from floor 0 to floor 2.
    step(4'b0100);
    #7;
    check("t2_latched", int'(pending), 4'b0100);
    check("t2_not_yet_moving", int'(moving), 0);
    run_until("t2_move", 3, 0, 50, ticks, cycles);
    check("t2_move_latency", cycles, 1);
    check("t2_up", int'(upsig), 1);
    run_until("t2_door", 0, 0, 200, ticks, cycles);
    check("t2_travel_ticks", ticks, 2 * FT);
    check("t2_floor", int'(floor), 2);
    check("t2_pending", int'(pending), 0);
    check("t2_up_kept", int'(upsig), 1);
    run_until("t2_close", 1, 0, 200, ticks, cycles);
    check("t2_dwell", ticks, DT);

    // 3: same-floor call and dwell restart.
    step(4'b0100);
    #7;
    check("t3_door", int'(door_open), 1);
    check("t3_moving", int'(moving), 0);
    check("t3_pending", int'(pending), 0);
    cnt = 0;
    while (cnt < 4) begin
      step('0);
      if (slowref) cnt++;
    end
    step(4'b0100);
    run_until("t3_close", 1, 0, 200, ticks, cycles);
    check("t3_dwell_restart", ticks, DT);

    // Park at floor 0.
    step(4'b0001);
    run_until("park0_door", 0, 0, 200, ticks, cycles);
    run_until("park0_idle", 1, 0, 200, ticks, cycles);

    // 4: pass-through stop.
    step(4'b1000);
    run_until("t4_at1", 2, 1, 200, ticks, cycles);
    step(4'b0100);
    #7;
    check("t4_pending_both", int'(pending), 4'b1100);
    run_until("t4_door2", 0, 0, 200, ticks, cycles);
    check("t4_floor2", int'(floor), 2);
    check("t4_pending_top", int'(pending), 4'b1000);
    run_until("t4_close2", 1, 0, 200, ticks, cycles);
    run_until("t4_door3", 0, 0, 200, ticks, cycles);
    check("t4_floor3", int'(floor), 3);
    check("t4_pending_none", int'(pending), 0);
    run_until("t4_idle", 1, 0, 200, ticks, cycles);

    // 5: direction persistence, then reversal 3 -> 0.
    step(4'b0001);
    run_until("t5_park0", 0, 0, 200, ticks, cycles);
    run_until("t5_idle0", 1, 0, 200, ticks, cycles);
    step(4'b1000);
    run_until("t5_at1", 2, 1, 200, ticks, cycles);
    step(4'b0001);
    run_until("t5_door3", 0, 0, 200, ticks, cycles);
    check("t5_floor3", int'(floor), 3);
    check("t5_up_kept", int'(upsig), 1);
    check("t5_behind", int'(pending), 4'b0001);
    run_until("t5_close", 1, 0, 200, ticks, cycles);
    run_until("t5_rev", 3, 0, 50, ticks, cycles);
    check("t5_dn", int'(dnsig), 1);
    check("t5_up_off", int'(upsig), 0);
    run_until("t5_door0", 0, 0, 300, ticks, cycles);
    check("t5_travel_ticks", ticks, 3 * FT);
    check("t5_floor0", int'(floor), 0);
    run_until("t5_idle", 1, 0, 200, ticks, cycles);

    // 6: reset while moving at floor 2 with calls pending.
    step(4'b1000);
    run_until("t6_at1", 2, 1, 200, ticks, cycles);
    step(4'b0001);
    run_until("t6_at2", 2, 2, 200, ticks, cycles);
    check("t6_pending", int'(pending), 4'b1001);
    rst_val = 1'b0;
    step('0);
    #1;
    check_all_zero("t6_async");
    step('0);
    step('0);
    rst_val = 1'b1;
    for (int k = 0; k < 30; k++) step('0);
    #7;
    check_all_zero("t6_after");

    // Random traffic against the model, with occasional resets.
    rand_sref = 1'b1;
    hold = 0;
    r = '0;
    for (int k = 0; k < 4000; k++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 9) == 0) begin
        r    = NF'($urandom_range(1, 15));
        hold = $urandom_range(0, 2);
      end else r = '0;
      rst_val = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      step(r);
    end
    rst_val = 1'b1;
    step('0);

    repeat (2) @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
